elevator_scan_ctrl: RTL and testbench
=====================================

Name: elevator_scan_ctrl

Overview:
- Parametrised N-floor elevator controller; successor to the 4-floor, 2-bit floor-state controller.
- Latches floor-call requests into a pending vector and serves them in SCAN order: keep going in the current direction while calls lie ahead, then reverse.
- Models travel time between floors and a timed door-open dwell.
- Drives the floor display and the motor/door actuators at top level.

Parameters:
- NUM_FLOORS, 8, number of floors (>=2); floors are numbered 0..NUM_FLOORS-1.
- FLOOR_W, $clog2(NUM_FLOORS), width of the floor index.
- MOVE_CYCLES, 4, clock cycles to travel one floor (>=1).
- DOOR_CYCLES, 6, clock cycles the door stays open (>=1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_FLOORS  floor-call inputs; bit i high for >=1 cycle requests floor i.
- floor  out  FLOOR_W  current car floor (registered).
- dir  out  1  travel direction: 1 = up, 0 = down (registered).
- moving  out  1  high while the car is in MOVING.
- door_open  out  1  high while the car is in DOOR.
- pending  out  NUM_FLOORS  latched outstanding calls (registered).

Behaviour:
- One clock; reset is synchronous and active-high. Interface signals are clk and rst.
- Reset values: floor=0, dir=1, moving=0, door_open=0, pending=0, state=IDLE, move_cnt=0, door_cnt=0. rst has priority over every other event, including mid-move and mid-dwell.
- Request latching:
  - Each edge: pending <= (pending | req) & ~clr.
  - clr is the one-hot bit of the floor being served on that edge.
  - A req bit for the floor being served on the same edge is absorbed and is not latched.
- Direction helpers, evaluated combinationally from pending and floor:
  - above = any pending bit with index > floor.
  - below = any pending bit with index < floor.
- IDLE (moving=0, door_open=0):
  - pending[floor]=1: go to DOOR, clear that bit, door_cnt=0.
  - Else if (dir=1 and above) or (dir=0 and below): go to MOVING, keep dir, move_cnt=0.
  - Else if above or below: flip dir, go to MOVING.
  - Else: stay in IDLE.
- MOVING (moving=1):
  - move_cnt increments every cycle.
  - When move_cnt==MOVE_CYCLES-1: floor <= floor+1 if dir=1, else floor-1; move_cnt <= 0. This is the arrival edge.
  - On the arrival edge, if pending[new floor]=1: go to DOOR and clear that bit on the same edge. Otherwise stay in MOVING.
  - If no call lies ahead after arrival: go to IDLE.
- DOOR (door_open=1):
  - door_cnt increments every cycle.
  - When door_cnt==DOOR_CYCLES-1: go to IDLE.
  - A req at the current floor during DOOR is absorbed and restarts the dwell (door_cnt <= 0).
- Bounds:
  - floor never leaves 0..NUM_FLOORS-1.
  - At floor 0, any departure is up; at the top floor, any departure is down.
  - The FSM never enters MOVING toward a side with no pending call.
- Latency:
  - req sampled at edge k, car IDLE at floor f, target g != f.
  - State is MOVING after edge k+1.
  - Floor reaches g at edge k+1+|g-f|*MOVE_CYCLES.
  - door_open is high for exactly DOOR_CYCLES cycles starting after that edge.
- Simultaneous events:
  - Multiple req bits in one cycle are all latched.
  - Calls behind the car wait until the reversal.
  - Calls ahead are picked up on the way in floor order.
- Widths: counters sized to $clog2(max(MOVE_CYCLES,DOOR_CYCLES))+1 bits; no wrap beyond terminal count.
- FSM encoding: IDLE, MOVING, DOOR as a 2-bit encoded state. The unused encoding returns to IDLE.

Test Plan:
- Reset: hold rst 2 cycles with req=8'hFF -> floor=0, dir=1, moving=0, door_open=0, pending=0 on the first post-reset cycle.
- Single call (defaults): idle at 0, req[3] one cycle at edge k:
  - floor steps 1,2,3 at edges k+5, k+9, k+13.
  - door_open high 6 cycles, then IDLE.
  - pending[3] cleared at edge k+13.
- SCAN order: car at floor 2 going up, req[5] and req[1] together -> stops at 5 first, dir flips to 0, then stops at 1; floor 1 is never served before 5.
- Own-floor and dwell extension:
  - Idle at 4, req[4] -> DOOR next edge, pending stays 0.
  - req[4] again at door_cnt=3 -> door_open lasts 3+1+6=10 cycles in total.
- Boundary: car at top floor 7 with dir=1, req[0] -> dir becomes 0 on departure; floor counts down to 0 and never exceeds 7.
- Reset mid-operation: assert rst during MOVING between floors 2 and 3 with pending=8'h28 -> all outputs return to reset values next edge and the latched calls are lost.

Source files
------------

// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator controller for NUM_FLOORS floors.
// Floor calls are latched into a pending vector. The car keeps moving in its
// current direction while calls remain ahead of it, and reverses otherwise.
// Travel between floors takes MOVE_CYCLES clocks and the door dwell takes
// DOOR_CYCLES clocks.
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = $clog2(NUM_FLOORS),
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int MAX_CYC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] ONE_BIT = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MOVING = 2'b01,
    DOOR   = 2'b10
  } state_t;

  state_t                  state_q, state_nx;
  logic [FLOOR_W-1:0]      floor_nx, step_floor;
  logic                    dir_nx;
  logic [CNT_W-1:0]        move_cnt, move_cnt_nx;
  logic [CNT_W-1:0]        door_cnt, door_cnt_nx;
  logic [NUM_FLOORS-1:0]   pending_nx, clr;
  logic                    above, below;

  // True when any call in p lies strictly above floor f.
  function automatic logic calls_above(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if ((FLOOR_W'(i) > f) && p[i]) r = 1'b1;
    return r;
  endfunction

  // True when any call in p lies strictly below floor f.
  function automatic logic calls_below(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if ((FLOOR_W'(i) < f) && p[i]) r = 1'b1;
    return r;
  endfunction

  assign moving    = (state_q == MOVING);
  assign door_open = (state_q == DOOR);

  // State, position, counters and call latch; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      floor    <= '0;
      dir      <= 1'b1;
      move_cnt <= '0;
      door_cnt <= '0;
      pending  <= '0;
    end else begin
      state_q  <= state_nx;
      floor    <= floor_nx;
      dir      <= dir_nx;
      move_cnt <= move_cnt_nx;
      door_cnt <= door_cnt_nx;
      pending  <= pending_nx;
    end
  end

  // SCAN next-state logic: serve own floor, continue ahead, or reverse.
  // An own-floor call is served on the same edge it is seen (including the
  // live req bit), so it never lingers in pending. Departure decisions use
  // only latched calls, so a new remote call departs one edge after latching.
  always_comb begin
    state_nx    = state_q;
    floor_nx    = floor;
    dir_nx      = dir;
    move_cnt_nx = move_cnt;
    door_cnt_nx = door_cnt;
    clr         = '0;
    above       = calls_above(pending, floor);
    below       = calls_below(pending, floor);
    step_floor  = dir ? (floor + FLOOR_W'(1)) : (floor - FLOOR_W'(1));

    case (state_q)
      IDLE: begin
        if (pending[floor] || req[floor]) begin
          state_nx    = DOOR;
          clr         = ONE_BIT << floor;
          door_cnt_nx = '0;
        end else if ((dir && above) || (!dir && below)) begin
          state_nx    = MOVING;
          move_cnt_nx = '0;
        end else if (above || below) begin
          dir_nx      = ~dir;
          state_nx    = MOVING;
          move_cnt_nx = '0;
        end
      end
      MOVING: begin
        if (move_cnt == MOVE_LAST) begin
          floor_nx    = step_floor;
          move_cnt_nx = '0;
          if (pending[step_floor] || req[step_floor]) begin
            state_nx    = DOOR;
            clr         = ONE_BIT << step_floor;
            door_cnt_nx = '0;
          end else if (dir ? !calls_above(pending, step_floor)
                           : !calls_below(pending, step_floor)) begin
            state_nx = IDLE;
          end
        end else begin
          move_cnt_nx = move_cnt + CNT_W'(1);
        end
      end
      DOOR: begin
        // Calls to the floor with the door already open are absorbed.
        clr = ONE_BIT << floor;
        if (req[floor]) begin
          door_cnt_nx = '0;
        end else if (door_cnt == DOOR_LAST) begin
          state_nx    = IDLE;
          door_cnt_nx = '0;
        end else begin
          door_cnt_nx = door_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    pending_nx = (pending | req) & ~clr;
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl: a vector table for the single-call,
// reversal and own-floor flow, plus sequences for SCAN order, dwell
// extension, top-floor reversal and reset during travel.
module tb_elevator_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [2:0] floor;
  logic       dir;
  logic       moving;
  logic       door_open;
  logic [7:0] pending;

  int n_chk;
  int n_pass;

  elevator_scan_ctrl #(
    .NUM_FLOORS(8),
    .FLOOR_W(3),
    .MOVE_CYCLES(4),
    .DOOR_CYCLES(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .floor(floor),
    .dir(dir),
    .moving(moving),
    .door_open(door_open),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] req;
    int         edges;
    logic [2:0] floor;
    logic       dir;
    logic       moving;
    logic       door;
    logic [7:0] pend;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issue one call and wait until the car has served it and closed the door.
  task automatic travel(input logic [7:0] r, input string tag);
    req = r;
    tick();
    req = 8'h00;
    for (int g = 0; g < 100 && !door_open; g++) tick();
    chk({tag, "_door"}, 32'(door_open), 32'd1);
    for (int g = 0; g < 20 && door_open; g++) tick();
    chk({tag, "_closed"}, 32'(door_open), 32'd0);
  endtask

  vec_t tbl[17];
  int   cnt;
  int   steps;
  bit   rose;
  logic [2:0] prev;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    req    = 8'h00;

    // Reset with all calls asserted: calls must not survive reset.
    rst = 1'b1;
    req = 8'hFF;
    tick();
    tick();
    chk("rst_floor",   32'(floor),     32'd0);
    chk("rst_dir",     32'(dir),       32'd1);
    chk("rst_moving",  32'(moving),    32'd0);
    chk("rst_door",    32'(door_open), 32'd0);
    chk("rst_pending", 32'(pending),   32'd0);
    rst = 1'b0;
    req = 8'h00;
    tick();
    chk("post_rst_pending", 32'(pending), 32'd0);
    chk("post_rst_moving",  32'(moving),  32'd0);

    // req, edges, floor, dir, moving, door, pending (after the last edge)
    tbl[0]  = '{8'h08, 1, 3'd0, 1'b1, 1'b0, 1'b0, 8'h08}; // edge k: latched
    tbl[1]  = '{8'h00, 1, 3'd0, 1'b1, 1'b1, 1'b0, 8'h08}; // k+1: MOVING
    tbl[2]  = '{8'h00, 3, 3'd0, 1'b1, 1'b1, 1'b0, 8'h08}; // k+4
    tbl[3]  = '{8'h00, 1, 3'd1, 1'b1, 1'b1, 1'b0, 8'h08}; // k+5: floor 1
    tbl[4]  = '{8'h00, 4, 3'd2, 1'b1, 1'b1, 1'b0, 8'h08}; // k+9: floor 2
    tbl[5]  = '{8'h00, 3, 3'd2, 1'b1, 1'b1, 1'b0, 8'h08}; // k+12
    tbl[6]  = '{8'h00, 1, 3'd3, 1'b1, 1'b0, 1'b1, 8'h00}; // k+13: arrive, door
    tbl[7]  = '{8'h00, 5, 3'd3, 1'b1, 1'b0, 1'b1, 8'h00}; // 6th door cycle
    tbl[8]  = '{8'h00, 1, 3'd3, 1'b1, 1'b0, 1'b0, 8'h00}; // IDLE
    tbl[9]  = '{8'h00, 2, 3'd3, 1'b1, 1'b0, 1'b0, 8'h00}; // stays IDLE
    tbl[10] = '{8'h01, 1, 3'd3, 1'b1, 1'b0, 1'b0, 8'h01}; // call behind
    tbl[11] = '{8'h00, 1, 3'd3, 1'b0, 1'b1, 1'b0, 8'h01}; // reverse, depart
    tbl[12] = '{8'h00, 4, 3'd2, 1'b0, 1'b1, 1'b0, 8'h01}; // floor 2 down
    tbl[13] = '{8'h00, 8, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00}; // arrive at 0
    tbl[14] = '{8'h00, 6, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00}; // dwell over
    tbl[15] = '{8'h01, 1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00}; // own floor: door now
    tbl[16] = '{8'h00, 6, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00}; // 6-cycle dwell

    for (int i = 0; i < 17; i++) begin
      req = tbl[i].req;
      tick();
      req = 8'h00;
      for (int e = 1; e < tbl[i].edges; e++) tick();
      chk($sformatf("vec%0d_floor", i),   32'(floor),     32'(tbl[i].floor));
      chk($sformatf("vec%0d_dir", i),     32'(dir),       32'(tbl[i].dir));
      chk($sformatf("vec%0d_moving", i),  32'(moving),    32'(tbl[i].moving));
      chk($sformatf("vec%0d_door", i),    32'(door_open), 32'(tbl[i].door));
      chk($sformatf("vec%0d_pending", i), 32'(pending),   32'(tbl[i].pend));
    end

    // SCAN order: at floor 2 heading up, calls at 5 and 1 together.
    do_reset();
    travel(8'h04, "scan_setup");
    chk("scan_setup_floor", 32'(floor), 32'd2);
    chk("scan_setup_dir",   32'(dir),   32'd1);
    req = 8'h22;
    tick();
    req = 8'h00;
    chk("scan_latched", 32'(pending), 32'h22);
    for (int g = 0; g < 100 && !door_open; g++) tick();
    chk("scan_first_stop", 32'(floor),   32'd5);
    chk("scan_first_pend", 32'(pending), 32'h02);
    chk("scan_first_dir",  32'(dir),     32'd1);
    for (int g = 0; g < 20 && !moving; g++) tick();
    chk("scan_reverse_dir", 32'(dir), 32'd0);
    for (int g = 0; g < 100 && !door_open; g++) tick();
    chk("scan_second_stop", 32'(floor),   32'd1);
    chk("scan_second_pend", 32'(pending), 32'h00);

    // Own-floor call at 4, then a repeat call at door_cnt==3 extends dwell.
    do_reset();
    travel(8'h10, "dwell_setup");
    chk("dwell_setup_floor", 32'(floor), 32'd4);
    req = 8'h10;
    tick();
    req = 8'h00;
    chk("own_floor_door", 32'(door_open), 32'd1);
    chk("own_floor_pend", 32'(pending),   32'h00);
    cnt = 0;
    for (int g = 0; g < 30 && door_open; g++) begin
      cnt++;
      req = (cnt == 4) ? 8'h10 : 8'h00;
      tick();
      if (cnt == 4) chk("dwell_absorb_pend", 32'(pending), 32'h00);
    end
    req = 8'h00;
    chk("dwell_total_cycles", 32'(cnt), 32'd10);

    // Top floor with dir up and a call at 0: reverse and count down.
    do_reset();
    travel(8'h80, "top_setup");
    chk("top_setup_floor", 32'(floor), 32'd7);
    chk("top_setup_dir",   32'(dir),   32'd1);
    req = 8'h01;
    tick();
    req = 8'h00;
    tick();
    chk("top_depart_dir",    32'(dir),    32'd0);
    chk("top_depart_moving", 32'(moving), 32'd1);
    chk("top_depart_floor",  32'(floor),  32'd7);
    steps = 0;
    rose  = 1'b0;
    prev  = floor;
    for (int g = 0; g < 100 && !door_open; g++) begin
      tick();
      steps++;
      if (floor > prev) rose = 1'b1;
      prev = floor;
    end
    chk("top_arrive_floor", 32'(floor), 32'd0);
    chk("top_travel_edges", 32'(steps), 32'd28);
    chk("top_never_rose",   32'(rose),  32'd0);

    // Reset while between floors 2 and 3 with calls at 3 and 5 latched.
    do_reset();
    req = 8'h28;
    tick();
    req = 8'h00;
    for (int g = 0; g < 100 && floor != 3'd2; g++) tick();
    tick();
    tick();
    chk("midrst_pre_moving", 32'(moving),  32'd1);
    chk("midrst_pre_floor",  32'(floor),   32'd2);
    chk("midrst_pre_pend",   32'(pending), 32'h28);
    rst = 1'b1;
    tick();
    chk("midrst_floor",   32'(floor),     32'd0);
    chk("midrst_dir",     32'(dir),       32'd1);
    chk("midrst_moving",  32'(moving),    32'd0);
    chk("midrst_door",    32'(door_open), 32'd0);
    chk("midrst_pending", 32'(pending),   32'h00);
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("midrst_after_moving",  32'(moving),  32'd0);
    chk("midrst_after_pending", 32'(pending), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
